// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (serial_subtractor, future serial_adder).
package serial_subtractor_pkg;

  localparam int unsigned SER_STATE_W = 2;

  typedef enum logic [SER_STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // Two half-subtractor stages; either stage borrowing produces the outgoing borrow.
  assign d1   = a ^ b;
  assign b1   = ~a & b;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

endmodule : full_subtractor_bit

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, one bit per clock LSB first, valid/ready on both sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH);

  ser_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             d_bit;
  logic             bout_bit;

  full_subtractor_bit u_fsb (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  // The borrow FF holds the final borrow after the last bit until the next accept.
  assign borrow_out = brw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      brw   <= 1'b0;
      diff  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          diff <= {d_bit, diff[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          brw  <= bout_bit;
          // Counter stops at WIDTH-1 rather than wrapping past it.
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an integer-arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;

  int unsigned errors = 0;
  int unsigned checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, wrapped modulo 2^W.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] md, output logic mbo);
    int r;
    r   = int'(ma) - int'(mb) - int'(mbin);
    mbo = (int'(ma) < int'(mb) + int'(mbin));
    md  = W'((r + (1 << W)) % (1 << W));
  endtask

  // Drives one operation; latency is counted in rising edges including the accept edge.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                        input int unsigned hold, input bit poke);
    logic [W-1:0] exp_d;
    logic         exp_bo;
    int unsigned  lat;
    model(oa, ob, obin, exp_d, exp_bo);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("busy_in_ready", in_ready, 0);
      if (poke) begin
        in_valid = 1'b1;
        a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, W + 1);
    chk("diff", diff, exp_d);
    chk("borrow_out", borrow_out, exp_bo);
    chk("done_in_ready", in_ready, 0);
    if (hold != 0) begin
      for (int i = 0; i < int'(hold); i++) begin
        in_valid = 1'b1;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        @(posedge clk); #1;
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_diff", diff, exp_d);
        chk("hold_borrow", borrow_out, exp_bo);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_diff_held", diff, exp_d);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd100, 8'd37, 1'b0, 0, 0);
    run_op(8'd5, 8'd9, 1'b1, 0, 0);
    run_op(8'hFF, 8'hFF, 1'b0, 0, 0);
    run_op(8'd0, 8'd0, 1'b1, 0, 0);
    run_op(8'd200, 8'd77, 1'b1, 20, 1);

    // Abort an operation partway through the shift phase.
    @(negedge clk);
    a = 8'hA5; b = 8'hF0; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd20, 8'd3, 1'b0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), (n % 8 == 3) ? 5 : 0, (n % 5 == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_subtractor
